// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive sequencer: capture FSM states,
// default slot geometry and the ready-synchroniser depth.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PAD     = 2'd3
    } rx_state_e;

    localparam int DEF_SAMPLE_WIDTH = 24;
    localparam int DEF_SLOT_WIDTH   = 32;
    localparam int SYNC_STAGES      = 2;

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO. A push and a pop in the same cycle both take
// effect, including when full; a pop while empty is ignored.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push = push && (!full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/i2s_rx_sequencer.sv
// Master-mode I2S receive sequencer: bclk/lrclk generation, slot-aligned
// capture into a sample FIFO, ready-handshaked readout. Optional macro
// I2S_RX_CHANNEL_TAG_EN stores the capture channel and exposes data_right.
module i2s_rx_sequencer
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH    = DEF_SLOT_WIDTH,
    parameter int CLK_DIV       = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int IRQ_THRESHOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    serial,
    input  logic                    ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    rpi_interrupt,
    output logic [SAMPLE_WIDTH-1:0] data,
    output logic                    overflow
`ifdef I2S_RX_CHANNEL_TAG_EN
    ,
    output logic                    data_right
`endif
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int CNT_W = cnt_width(SLOT_WIDTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef I2S_RX_CHANNEL_TAG_EN
    localparam int FIFO_W = SAMPLE_WIDTH + 1;
`else
    localparam int FIFO_W = SAMPLE_WIDTH;
`endif

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic                    lrclk_q, lrclk_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    rx_state_e               state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic                    push_q, push_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    ready_prev_q, ready_prev_d;
    logic                    ovf_q, ovf_d;
    logic                    irq_q, irq_d;
    logic [SAMPLE_WIDTH-1:0] data_q, data_d;

    logic                    div_tc, sample_stb, shift_stb, cnt_last;
    logic                    cap_en, cap_last, pop;
    logic [FIFO_W-1:0]       fifo_wdata, fifo_head;
    logic [LVL_W-1:0]        fifo_level;
    logic                    fifo_full, fifo_empty;

    // bclk rises on one terminal count and falls on the next; the rising
    // edge samples serial, the falling edge advances the slot position.
    always_comb begin
        div_tc     = (div_q == DIV_W'(CLK_DIV - 1));
        div_d      = div_tc ? '0 : div_q + DIV_W'(1);
        bclk_d     = bclk_q ^ div_tc;
        sample_stb = div_tc && !bclk_q;
        shift_stb  = div_tc && bclk_q;

        cnt_last = (cnt_q == CNT_W'(SLOT_WIDTH - 1));
        cnt_d    = cnt_q;
        if (shift_stb) begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        end
        lrclk_d = lrclk_q ^ (shift_stb && cnt_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions are taken on the sample strobe of the last bit before the
    // state's bit range starts, so DELAY always sees bit 0 of a slot.
    always_comb begin
        state_d = state_q;
        if (sample_stb) begin
            case (state_q)
                ST_SYNC: begin
                    if (cnt_last && lrclk_q) begin
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (cnt_q == CNT_W'(SAMPLE_WIDTH)) begin
                        state_d = cnt_last ? ST_DELAY : ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (cnt_last) begin
                        state_d = ST_DELAY;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        cap_en   = sample_stb && (state_q == ST_CAPTURE);
        cap_last = cap_en && (cnt_q == CNT_W'(SAMPLE_WIDTH));
    end

    always_comb begin
        shreg_d = cap_en ? {shreg_q[SAMPLE_WIDTH-2:0], serial} : shreg_q;
        push_d  = cap_last;

        sync_d       = {sync_q[SYNC_STAGES-2:0], ready};
        ready_prev_d = sync_q[SYNC_STAGES-1];
        pop          = sync_q[SYNC_STAGES-1] && !ready_prev_q;

        ovf_d  = ovf_q || (push_q && fifo_full && !pop);
        irq_d  = (fifo_level >= LVL_W'(IRQ_THRESHOLD));
        data_d = fifo_empty ? data_q : fifo_head[SAMPLE_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            cnt_q        <= '0;
            push_q       <= 1'b0;
            sync_q       <= '0;
            ready_prev_q <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
            data_q       <= '0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            cnt_q        <= cnt_d;
            push_q       <= push_d;
            sync_q       <= sync_d;
            ready_prev_q <= ready_prev_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
            data_q       <= data_d;
        end
    end

    // The shift register is fully rewritten before every push.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

`ifdef I2S_RX_CHANNEL_TAG_EN
    logic tag_q, tag_d;
    logic right_q, right_d;

    always_comb begin
        tag_d      = cap_last ? lrclk_q : tag_q;
        right_d    = fifo_empty ? right_q : fifo_head[SAMPLE_WIDTH];
        fifo_wdata = {tag_q, shreg_q};
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (rst) begin
            right_q <= 1'b0;
        end else begin
            right_q <= right_d;
        end
    end

    assign data_right = right_q;
`else
    always_comb begin
        fifo_wdata = shreg_q;
    end
`endif

    i2s_sample_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bclk          = bclk_q;
    assign lrclk         = lrclk_q;
    assign rpi_interrupt = irq_q;
    assign data          = data_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Bench for i2s_rx_sequencer: a codec model drives serial from bclk/lrclk,
// and a queue-based reference model predicts FIFO readout cycle by cycle.
`timescale 1ns/1ps
module tb_i2s_rx_sequencer;

    localparam int SW     = 24;
    localparam int SLOT   = 32;
    localparam int CDIV   = 2;
    localparam int DEPTH  = 4;
    localparam int THR    = 1;
    localparam int NSLOT  = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial = 1'b0;
    logic          ready = 1'b0;
    logic          bclk, lrclk, rpi_interrupt, overflow;
    logic [SW-1:0] data;
`ifdef I2S_RX_CHANNEL_TAG_EN
    logic          data_right;
`endif

    i2s_rx_sequencer #(
        .SAMPLE_WIDTH  (SW),
        .SLOT_WIDTH    (SLOT),
        .CLK_DIV       (CDIV),
        .FIFO_DEPTH    (DEPTH),
        .IRQ_THRESHOLD (THR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial        (serial),
        .ready         (ready),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .rpi_interrupt (rpi_interrupt),
        .data          (data),
        .overflow      (overflow)
`ifdef I2S_RX_CHANNEL_TAG_EN
        ,
        .data_right    (data_right)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Edge-sampled copies of the driven inputs plus a count of active edges
    // since reset release.
    logic rst_e   = 1'b1;
    logic ready_e = 1'b0;
    int   k       = 0;

    always @(posedge clk) begin
        rst_e   <= rst;
        ready_e <= ready;
        k       <= rst ? 0 : k + 1;
    end

    logic [SW-1:0] slot_val [NSLOT];

    function automatic logic [SW-1:0] slot_sample(input int s);
        return slot_val[(s < NSLOT) ? s : NSLOT - 1];
    endfunction

    // Codec: new bit on each falling bclk, bit index restarts when lrclk
    // changes, MSB appears one bit after the slot starts.
    initial begin
        int            bidx;
        int            slot;
        logic          bprev;
        logic          lrprev;
        logic [SW-1:0] sv;
        bidx = 0; slot = 0; bprev = 1'b0; lrprev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_e) begin
                bidx = 0; slot = 0; bprev = 1'b0; lrprev = 1'b0;
            end else begin
                if (bprev && !bclk) begin
                    if (lrclk != lrprev) begin
                        slot++;
                        bidx = 0;
                    end else begin
                        bidx++;
                    end
                    lrprev = lrclk;
                end
                bprev = bclk;
            end
            if (bidx >= 1 && bidx <= SW) begin
                sv     = slot_sample(slot);
                serial = sv[SW-bidx];
            end else begin
                serial = 1'($urandom);
            end
        end
    end

    // A sample lands in the FIFO one edge after the rising bclk that carries
    // its last bit; slots 0 and 1 precede the first complete left slot.
    function automatic bit push_edge(input int kk, output int s);
        int t;
        int m;
        t = kk - 1;
        s = 0;
        if (t < CDIV || (t % CDIV) != 0 || ((t / CDIV) % 2) != 1) return 1'b0;
        m = (t / CDIV - 1) / 2;
        s = m / SLOT;
        return ((m % SLOT) == SW) && (s >= 2);
    endfunction

    logic [SW:0]   mq[$];
    logic [SW-1:0] data_hold;
    logic          tag_hold;
    logic          ovf_m;
    logic          irq_exp;
    logic          rdy_prev;
    int            cd;

    always @(negedge clk) begin
        int pslot;
        int pre;
        bit push_now, pop_now, do_push, do_pop;
        if (rst_e) begin
            mq.delete();
            data_hold = '0;
            tag_hold  = 1'b0;
            ovf_m     = 1'b0;
            irq_exp   = 1'b0;
            rdy_prev  = 1'b0;
            cd        = 0;
        end else begin
            irq_exp = (mq.size() >= THR);
            if (mq.size() > 0) {tag_hold, data_hold} = mq[0];
            pop_now = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) pop_now = 1'b1;
            end
            if (ready_e && !rdy_prev) cd = 2;
            rdy_prev = ready_e;
            push_now = push_edge(k, pslot);
            pre      = mq.size();
            do_pop   = pop_now && (pre > 0);
            do_push  = push_now && ((pre < DEPTH) || do_pop);
            if (push_now && !do_push) ovf_m = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({1'(pslot % 2), slot_sample(pslot)});
        end
        check("bclk", 32'(bclk), 32'((k / CDIV) % 2));
        check("lrclk", 32'(lrclk), 32'((k / (2 * CDIV * SLOT)) % 2));
        check("irq", 32'(rpi_interrupt), 32'(irq_exp));
        check("data", 32'(data), 32'(data_hold));
        check("overflow", 32'(overflow), 32'(ovf_m));
`ifdef I2S_RX_CHANNEL_TAG_EN
        check("data_right", 32'(data_right), 32'(tag_hold));
`endif
    end

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (k < target) check("wait_timeout", 32'(k), 32'(target));
    endtask

    task automatic pulse_ready();
        #1 ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NSLOT; i++) slot_val[i] = SW'($urandom);
        slot_val[2] = 24'hA5F00F;
        slot_val[3] = 24'h123456;

        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_irq", 32'(rpi_interrupt), 32'h0);
        #1 rst = 1'b0;

        // Reset in the middle of capturing the first left sample.
        wait_k(300);
        apply_reset(3);

        wait_k(200);
        check("no_push_before_sync", 32'(rpi_interrupt), 32'h0);
        wait_k(355);
        check("irq_not_yet", 32'(rpi_interrupt), 32'h0);
        wait_k(356);
        check("irq_rise", 32'(rpi_interrupt), 32'h1);
        check("first_left", 32'(data), 32'hA5F00F);
        check("no_ovf_early", 32'(overflow), 32'h0);

        wait_k(490);
        pulse_ready();
        check("after_pop_data", 32'(data), 32'h123456);
        check("after_pop_irq", 32'(rpi_interrupt), 32'h1);

        // No reads for several slots: FIFO fills and one sample is dropped.
        wait_k(1000);
        check("ovf_set", 32'(overflow), 32'h1);
        check("full_head", 32'(data), 32'h123456);
        repeat (4) pulse_ready();
        wait_k(1030);
        check("irq_fall", 32'(rpi_interrupt), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        apply_reset(2);
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Pop lands on the same edge as the push into a full FIFO.
        wait_k(864);
        pulse_ready();
        wait_k(900);
        check("coincide_no_ovf", 32'(overflow), 32'h0);
        check("coincide_head", 32'(data), 32'h123456);
        repeat (4) pulse_ready();
        wait_k(930);
        check("coincide_drained", 32'(rpi_interrupt), 32'h0);

        wait_k(1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
